// File: rtl/led7_pkg.sv
//============================================================
// led7_pkg : 7-segment font, segment constants and helpers
// Rev 1.0
//============================================================
`default_nettype none

package led7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [0:0] {
    CONV_IDLE  = 1'b0,
    CONV_SHIFT = 1'b1
  } conv_state_t;

  function automatic int cnt_width(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

  // Bit order {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg_font(input logic [3:0] nib);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h18;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_7seg_scan_if.sv
//============================================================
// led_7seg_scan_if : load/value request bus for the display driver
// Rev 1.0
//============================================================
`default_nettype none

interface led_7seg_scan_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              dec_mode;
  logic              busy;

  modport master (output data_in, output load, output dec_mode, input busy);
  modport slave  (input data_in, input load, input dec_mode, output busy);
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
//============================================================
// bin2bcd_seq : sequential double-dabble, one shift per cycle
// Rev 1.0
//============================================================
`default_nettype none

module bin2bcd_seq
  import led7_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start,
  input  wire logic [DATA_W-1:0]     bin,
  output logic                       busy,
  output logic                       done,
  output logic [4*DIGITS-1:0]        bcd,
  output logic                       ovf
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = $clog2(DATA_W + 1);

  conv_state_t          r_state;
  conv_state_t          w_state_nxt;
  logic [DATA_W-1:0]    r_bin;
  logic [c_bcd_w-1:0]   r_bcd;
  logic [c_bcd_w-1:0]   w_adj;
  logic [c_bcd_w-1:0]   w_shift;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_ovf;
  logic                 w_carry;
  logic                 w_last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                       : r_bcd[4*i +: 4];
  end

  // A bit leaving the top digit means the value needs more than DIGITS digits
  assign w_shift = {w_adj[c_bcd_w-2:0], r_bin[DATA_W-1]};
  assign w_carry = w_adj[c_bcd_w-1];
  assign w_last  = (r_cnt == c_cnt_w'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CONV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    case (r_state)
      CONV_IDLE: begin
        if (start) w_state_nxt = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        if (w_last) begin
          done        = 1'b1;
          w_state_nxt = CONV_IDLE;
        end
      end
      default: w_state_nxt = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == CONV_IDLE) begin
      if (start) begin
        r_bin <= bin;
        r_bcd <= '0;
        r_cnt <= c_cnt_w'(DATA_W);
        r_ovf <= 1'b0;
      end
    end else begin
      r_bin <= r_bin << 1;
      r_bcd <= w_shift;
      r_cnt <= r_cnt - 1'b1;
      r_ovf <= r_ovf | w_carry;
    end
  end

  // bcd/ovf present the result of the shift in progress so the caller can
  // capture the final value on the same edge that busy falls
  assign busy = (r_state == CONV_SHIFT);
  assign bcd  = w_shift;
  assign ovf  = r_ovf | w_carry;

endmodule

`default_nettype wire

// File: rtl/led_7seg_scan.sv
//============================================================
// led_7seg_scan : time-multiplexed N-digit 7-segment driver, hex/decimal
// Rev 1.0
//============================================================
`default_nettype none

module led_7seg_scan
  import led7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 50000
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  led_7seg_scan_if.slave      bus,
  input  wire logic           blank_lz,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int c_bcd_w = 4 * DIGITS;
  localparam int c_cnt_w = cnt_width(SCAN_DIV);
  localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] c_an_one = DIGITS'(1);

  logic                  w_busy;
  logic                  w_done;
  logic [c_bcd_w-1:0]    w_conv_bcd;
  logic                  w_conv_ovf;
  logic                  w_accept;
  logic                  w_start;

  logic [c_bcd_w-1:0]    r_disp;
  logic                  r_ovf;
  logic [c_cnt_w-1:0]    r_scan_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_an;

  logic [3:0]            w_digits [DIGITS];
  logic [DIGITS-1:0]     w_zero_above;
  logic [3:0]            w_cur;
  logic [6:0]            w_seg_nxt;
  logic [DIGITS-1:0]     w_an_nxt;

  assign w_accept = bus.load & ~w_busy;
  assign w_start  = w_accept & bus.dec_mode;
  assign bus.busy = w_busy;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .bin   (bus.data_in),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_conv_bcd),
    .ovf   (w_conv_ovf)
  );

  // done and accept are exclusive: done only occurs while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp <= '0;
      r_ovf  <= 1'b0;
    end else if (w_done) begin
      r_disp <= w_conv_bcd;
      r_ovf  <= w_conv_ovf;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
      if (!bus.dec_mode) r_disp <= c_bcd_w'(bus.data_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == c_cnt_w'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_digits[i]     = r_disp[4*i +: 4];
    assign w_zero_above[i] = (r_disp[c_bcd_w-1:4*i] == '0);
  end

  always_comb begin
    w_cur     = w_digits[r_idx];
    w_an_nxt  = ~(c_an_one << r_idx);
    w_seg_nxt = seg_font(w_cur);
    if (r_ovf) begin
      w_seg_nxt = SEG_DASH;
    end else if (blank_lz && (r_idx != '0) && w_zero_above[r_idx]) begin
      w_seg_nxt = SEG_BLANK;
    end
  end

  // Outputs load only at the start of a digit slot, so a display update
  // never changes the pattern partway through a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else if (r_scan_cnt == '0) begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

`default_nettype wire

// File: tb/tb_led_7seg_scan.sv
//============================================================
// tb_led_7seg_scan : randomized self-checking bench with display model
// Rev 1.0
//============================================================
`default_nettype none

module tb_led_7seg_scan;

  localparam int DIGITS     = 4;
  localparam int DATA_W     = 16;
  localparam int SCAN_DIV   = 4;
  localparam int CONV_BOUND = 64;

  // Font in a..g order (leftmost = segment a), 0 = lit
  localparam logic [6:0] FONT_AG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              blank_lz = 1'b0;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  led_7seg_scan_if #(.DATA_W(DATA_W)) bus ();

  led_7seg_scan #(
    .DIGITS   (DIGITS),
    .DATA_W   (DATA_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int m_val    = 0;
  bit m_dec    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int i);
    int         dig;
    bit         lead;
    logic [6:0] ag;
    logic [6:0] r;
    if (m_dec && m_val > 10**DIGITS - 1) return 7'b0111111;
    if (m_dec) begin
      dig  = (m_val / (10**i)) % 10;
      lead = (m_val < 10**i);
    end else begin
      dig  = (m_val >> (4*i)) & 15;
      lead = (m_val < (1 << (4*i)));
    end
    if (blank_lz && i > 0 && lead) return 7'h7F;
    ag = FONT_AG[dig];
    for (int k = 0; k < 7; k++) r[k] = ag[6-k];
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] exp_an(input int i);
    logic [DIGITS-1:0] e;
    e    = '1;
    e[i] = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Each cycle: which digit should be lit follows purely from time since reset
  task automatic observe(input int ncyc);
    int idx;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      idx = ((cyc - 1) / SCAN_DIV) % DIGITS;
      chk("an",  32'(an),  32'(exp_an(idx)));
      chk("seg", 32'(seg), 32'(exp_seg(idx)));
    end
  endtask

  task automatic show();
    repeat (SCAN_DIV) tick();
    observe(DIGITS * SCAN_DIV);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    bus.load = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_seg",  32'(seg),      32'h7F);
    chk("rst_an",   32'(an),       32'hF);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc   = 0;
    m_val = 0;
    m_dec = 1'b0;
    #1;
    chk("rst_hold_an", 32'(an), 32'hF);
  endtask

  task automatic pulse_load(input int val, input bit dec);
    int n;
    n = 0;
    while (bus.busy && n < CONV_BOUND) begin
      tick();
      n++;
    end
    bus.data_in  = DATA_W'(val);
    bus.dec_mode = dec;
    bus.load     = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic do_load(input int val, input bit dec);
    int n;
    pulse_load(val, dec);
    if (!dec) begin
      chk("hex_busy", 32'(bus.busy), 32'd0);
      tick();
      chk("hex_busy", 32'(bus.busy), 32'd0);
    end else begin
      n = 0;
      // Stray loads mid-conversion and on the falling-busy edge must be dropped
      while (bus.busy && n < CONV_BOUND) begin
        n++;
        bus.load     = (n == 3 || n == DATA_W);
        bus.data_in  = ~DATA_W'(val);
        bus.dec_mode = 1'($urandom);
        tick();
      end
      bus.load = 1'b0;
      chk("busy_cycles", 32'(n), 32'(DATA_W));
      tick();
      chk("no_requeue", 32'(bus.busy), 32'd0);
    end
    m_val = val;
    m_dec = dec;
  endtask

  initial begin
    bus.data_in  = '0;
    bus.load     = 1'b0;
    bus.dec_mode = 1'b0;

    do_reset();
    observe(2 * DIGITS * SCAN_DIV);
    repeat (6) tick();
    do_reset();
    observe(DIGITS * SCAN_DIV);

    do_load(16'h1A3F, 1'b0); show();
    do_load(1234, 1'b1);     show();
    do_load(12345, 1'b1);    show();
    do_load(16'h0007, 1'b0); show();

    blank_lz = 1'b1;
    do_load(16'h0050, 1'b0); show();
    do_load(0, 1'b0);        show();
    do_load(50, 1'b1);       show();
    blank_lz = 1'b0;

    pulse_load(4321, 1'b1);
    repeat (5) tick();
    chk("conv_running", 32'(bus.busy), 32'd1);
    do_reset();
    observe(DIGITS * SCAN_DIV);
    do_load(1234, 1'b1); show();

    for (int it = 0; it < 20; it++) begin
      int v;
      bit d;
      d        = 1'($urandom);
      blank_lz = 1'($urandom);
      if (d) v = $urandom_range(0, 1) ? int'($urandom_range(0, 9999))
                                      : int'($urandom_range(0, 65535));
      else   v = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      do_load(v, d);
      show();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
